// File: rtl/day_countdown_timer.sv
// ----------------------------------------------------------------------------
// day_countdown_timer : calendar-style Y/M/D h:m:s countdown, one second per tick
// Optional feature macro: AUTO_RELOAD_EN (reload from captured value on expiry)
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module day_countdown_timer #(
  parameter int MAX_SECOND = 59,
  parameter int MAX_MINUTE = 59,
  parameter int MAX_HOUR   = 23,
  parameter int MAX_DAY    = 30,
  parameter int MAX_MONTH  = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [5:0] ld_year,
  input  logic [3:0] ld_month,
  input  logic [4:0] ld_day,
  input  logic [4:0] ld_hour,
  input  logic [5:0] ld_minute,
  input  logic [5:0] ld_second,
  input  logic       start,
  input  logic       stop,
  input  logic       tick,
  output logic [5:0] year,
  output logic [3:0] month,
  output logic [4:0] day,
  output logic [4:0] hour,
  output logic [5:0] minute,
  output logic [5:0] second,
  output logic       running,
  output logic       done,
  output logic       expired
);

`ifdef AUTO_RELOAD_EN
  localparam bit c_AUTO_RELOAD = 1'b1;
`else
  localparam bit c_AUTO_RELOAD = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_done;
  logic [31:0] r_cnt;
  logic [31:0] r_reload;

  logic [3:0]  w_ld_month;
  logic [4:0]  w_ld_day;
  logic [4:0]  w_ld_hour;
  logic [5:0]  w_ld_minute;
  logic [5:0]  w_ld_second;
  logic [31:0] w_ld_cnt;
  logic [5:0]  w_yr, w_mi, w_se;
  logic [3:0]  w_mo;
  logic [4:0]  w_dy, w_hr;
  logic [31:0] w_dec;
  logic        w_cnt_zero;
  logic        w_dec_zero;
  logic        w_reload_zero;

  assign w_ld_month  = (ld_month  > 4'(MAX_MONTH))  ? 4'(MAX_MONTH)  : ld_month;
  assign w_ld_day    = (ld_day    > 5'(MAX_DAY))    ? 5'(MAX_DAY)    : ld_day;
  assign w_ld_hour   = (ld_hour   > 5'(MAX_HOUR))   ? 5'(MAX_HOUR)   : ld_hour;
  assign w_ld_minute = (ld_minute > 6'(MAX_MINUTE)) ? 6'(MAX_MINUTE) : ld_minute;
  assign w_ld_second = (ld_second > 6'(MAX_SECOND)) ? 6'(MAX_SECOND) : ld_second;
  assign w_ld_cnt    = {ld_year, w_ld_month, w_ld_day, w_ld_hour, w_ld_minute, w_ld_second};

  assign {w_yr, w_mo, w_dy, w_hr, w_mi, w_se} = r_cnt;

  // Borrow ripples upward only while each lower field sits at zero.
  always_comb begin
    logic [5:0] v_se, v_mi, v_yr;
    logic [4:0] v_hr, v_dy;
    logic [3:0] v_mo;
    logic       v_b;
    v_b  = 1'b1;
    v_se = w_se; v_mi = w_mi; v_hr = w_hr;
    v_dy = w_dy; v_mo = w_mo; v_yr = w_yr;
    if (w_se != 6'd0) begin v_se = w_se - 6'd1; v_b = 1'b0; end
    else              v_se = 6'(MAX_SECOND);
    if (v_b) begin
      if (w_mi != 6'd0) begin v_mi = w_mi - 6'd1; v_b = 1'b0; end
      else              v_mi = 6'(MAX_MINUTE);
    end
    if (v_b) begin
      if (w_hr != 5'd0) begin v_hr = w_hr - 5'd1; v_b = 1'b0; end
      else              v_hr = 5'(MAX_HOUR);
    end
    if (v_b) begin
      if (w_dy != 5'd0) begin v_dy = w_dy - 5'd1; v_b = 1'b0; end
      else              v_dy = 5'(MAX_DAY);
    end
    if (v_b) begin
      if (w_mo != 4'd0) begin v_mo = w_mo - 4'd1; v_b = 1'b0; end
      else              v_mo = 4'(MAX_MONTH);
    end
    if (v_b) v_yr = w_yr - 6'd1;
    w_dec = {v_yr, v_mo, v_dy, v_hr, v_mi, v_se};
  end

  assign w_cnt_zero    = (r_cnt == 32'd0);
  assign w_dec_zero    = (w_dec == 32'd0);
  assign w_reload_zero = (r_reload == 32'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_done   <= 1'b0;
      r_cnt    <= 32'd0;
      r_reload <= 32'd0;
    end else begin
      r_done <= 1'b0;
      if (load) begin
        r_cnt    <= w_ld_cnt;
        r_reload <= w_ld_cnt;
        r_state  <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE, S_PAUSE: begin
            if (start) begin
              if (w_cnt_zero) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state <= S_RUN;
              end
            end
          end
          S_RUN: begin
            if (stop) begin
              r_state <= S_PAUSE;
            end else if (tick && !w_cnt_zero) begin
              if (w_dec_zero) begin
                r_done <= 1'b1;
                if (c_AUTO_RELOAD && !w_reload_zero) begin
                  r_cnt <= r_reload;
                end else begin
                  r_cnt   <= w_dec;
                  r_state <= S_DONE;
                end
              end else begin
                r_cnt <= w_dec;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign {year, month, day, hour, minute, second} = r_cnt;
  assign running = (r_state == S_RUN);
  assign expired = (r_state == S_DONE);
  assign done    = r_done;

endmodule

`default_nettype wire

// File: tb/tb_day_countdown_timer.sv
// ----------------------------------------------------------------------------
// tb_day_countdown_timer : self-checking bench, directed steps plus random ops
// against a total-seconds reference model. Honours AUTO_RELOAD_EN.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_day_countdown_timer;

  logic       clk;
  logic       reset;
  logic       load, start, stop, tick;
  logic [5:0] ld_year, ld_minute, ld_second;
  logic [3:0] ld_month;
  logic [4:0] ld_day, ld_hour;
  logic [5:0] year, minute, second;
  logic [3:0] month;
  logic [4:0] day, hour;
  logic       running, done, expired;

  int tests;
  int fails;

  day_countdown_timer dut (
    .clk(clk), .reset(reset), .load(load),
    .ld_year(ld_year), .ld_month(ld_month), .ld_day(ld_day),
    .ld_hour(ld_hour), .ld_minute(ld_minute), .ld_second(ld_second),
    .start(start), .stop(stop), .tick(tick),
    .year(year), .month(month), .day(day), .hour(hour),
    .minute(minute), .second(second),
    .running(running), .done(done), .expired(expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the count is one mixed-radix integer of seconds.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
  longint m_cnt, m_rel;
  int     m_st;
  bit     m_done;

  function automatic longint to_secs(int y, int mo, int d, int h, int mi, int s);
    return ((((longint'(y) * 13 + mo) * 31 + d) * 24 + h) * 60 + mi) * 60 + s;
  endfunction

  function automatic logic [31:0] to_fields(longint v);
    int s, mi, h, d, mo, y;
    s  = int'(v % 60); v = v / 60;
    mi = int'(v % 60); v = v / 60;
    h  = int'(v % 24); v = v / 24;
    d  = int'(v % 31); v = v / 31;
    mo = int'(v % 13); v = v / 13;
    y  = int'(v);
    return {6'(y), 4'(mo), 5'(d), 5'(h), 6'(mi), 6'(s)};
  endfunction

  function automatic int sat(int v, int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic bit auto_reload();
`ifdef AUTO_RELOAD_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_rel = 0; m_st = M_IDLE; m_done = 0;
  endtask

  task automatic model_step();
    m_done = 0;
    if (load) begin
      m_cnt = to_secs(ld_year, sat(ld_month, 12), sat(ld_day, 30),
                      sat(ld_hour, 23), sat(ld_minute, 59), sat(ld_second, 59));
      m_rel = m_cnt;
      m_st  = M_IDLE;
    end else if (m_st == M_RUN && stop) begin
      m_st = M_PAUSE;
    end else if ((m_st == M_IDLE || m_st == M_PAUSE) && start) begin
      if (m_cnt == 0) begin m_st = M_DONE; m_done = 1; end
      else m_st = M_RUN;
    end else if (m_st == M_RUN && tick && m_cnt != 0) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        m_done = 1;
        if (auto_reload() && m_rel != 0) m_cnt = m_rel;
        else m_st = M_DONE;
      end
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(string tag);
    chk({tag, ".count"},   {year, month, day, hour, minute, second}, to_fields(m_cnt));
    chk({tag, ".running"}, 32'(running), 32'(m_st == M_RUN));
    chk({tag, ".done"},    32'(done),    32'(m_done));
    chk({tag, ".expired"}, 32'(expired), 32'(m_st == M_DONE));
  endtask

  task automatic set_ld(int y, int mo, int d, int h, int mi, int s);
    ld_year = 6'(y); ld_month = 4'(mo); ld_day = 5'(d);
    ld_hour = 5'(h); ld_minute = 6'(mi); ld_second = 6'(s);
  endtask

  task automatic step(string tag, bit l, bit sa, bit sp, bit tk);
    load = l; start = sa; stop = sp; tick = tk;
    @(posedge clk);
    model_step();
    #1;
    chk_model(tag);
    load = 0; start = 0; stop = 0; tick = 0;
  endtask

  initial begin
    tests = 0; fails = 0;
    reset = 0; load = 0; start = 0; stop = 0; tick = 0;
    set_ld(0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_model("reset");
    reset = 1;

    // Mid-run asynchronous reset
    set_ld(0, 0, 0, 0, 1, 5);
    step("rst_ld", 1, 0, 0, 0);
    step("rst_go", 0, 1, 0, 0);
    step("rst_tk", 0, 0, 0, 1);
    chk("rst_pre", {year, month, day, hour, minute, second}, {6'd0, 4'd0, 5'd0, 5'd0, 6'd1, 6'd4});
    #2 reset = 0;
    #1;
    model_reset();
    chk("rst_async", {26'd0, year, running, done, expired}, 32'd0);
    chk("rst_async_cnt", {year, month, day, hour, minute, second}, 32'd0);
    @(posedge clk); #3 reset = 1;
    @(posedge clk); #1;
    chk_model("rst_rel");

    // Full borrow chain
    set_ld(1, 0, 0, 0, 0, 0);
    step("bor_ld", 1, 0, 0, 0);
    step("bor_go", 0, 1, 0, 0);
    step("bor_tk", 0, 0, 0, 1);
    chk("borrow", {year, month, day, hour, minute, second}, {6'd0, 4'd12, 5'd30, 5'd23, 6'd59, 6'd59});
    chk("bor_run", {30'd0, running, done}, 32'd2);

    // Expiry (one-shot behaviour only)
    if (!auto_reload()) begin
      set_ld(0, 0, 0, 0, 0, 2);
      step("exp_ld", 1, 0, 0, 0);
      step("exp_go", 0, 1, 0, 0);
      step("exp_t1", 0, 0, 0, 1);
      step("exp_t2", 0, 0, 0, 1);
      chk("exp_pulse", {29'd0, running, done, expired}, 32'd3);
      chk("exp_zero", {year, month, day, hour, minute, second}, 32'd0);
      step("exp_idle", 0, 0, 0, 0);
      chk("exp_after", {29'd0, running, done, expired}, 32'd1);
      step("exp_t3", 0, 0, 0, 1);
      chk("exp_nounder", {year, month, day, hour, minute, second}, 32'd0);
    end

    // Pause / resume
    set_ld(0, 0, 0, 0, 1, 0);
    step("pz_ld", 1, 0, 0, 0);
    step("pz_go", 0, 1, 0, 0);
    for (int i = 0; i < 10; i++) step("pz_run", 0, 0, 0, 1);
    step("pz_stop", 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) step("pz_held", 0, 0, 0, 1);
    chk("pz_paused", 32'(running), 32'd0);
    step("pz_res", 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step("pz_run2", 0, 0, 0, 1);
    chk("pz_final", {year, month, day, hour, minute, second}, 32'd47);

    // Priority: load beats stop/start/tick in RUN; saturation
    set_ld(0, 0, 0, 0, 0, 9);
    step("pri", 1, 1, 1, 1);
    chk("pri_cnt", {year, month, day, hour, minute, second}, 32'd9);
    chk("pri_state", {29'd0, running, done, expired}, 32'd0);
    set_ld(0, 0, 0, 0, 63, 0);
    step("sat", 1, 0, 0, 0);
    chk("sat_min", 32'(minute), 32'd59);

    // Start with all-zero count goes straight to DONE
    set_ld(0, 0, 0, 0, 0, 0);
    step("z_ld", 1, 0, 0, 0);
    step("z_go", 0, 1, 0, 0);
    chk("z_done", {29'd0, running, done, expired}, 32'd3);

    // Auto-reload scenario
    if (auto_reload()) begin
      set_ld(0, 0, 0, 0, 0, 3);
      step("ar_ld", 1, 0, 0, 0);
      step("ar_go", 0, 1, 0, 0);
      for (int i = 1; i <= 7; i++) begin
        step("ar_tk", 0, 0, 0, 1);
        chk("ar_done", 32'(done), 32'((i == 3) || (i == 6)));
      end
      chk("ar_cnt", {year, month, day, hour, minute, second}, 32'd2);
      chk("ar_state", {29'd0, running, done, expired}, 32'd4);
    end

    // Randomised operations against the model
    for (int n = 0; n < 600; n++) begin
      bit l, sa, sp, tk;
      l  = ($urandom_range(0, 99) < 4);
      sa = ($urandom_range(0, 99) < 12);
      sp = ($urandom_range(0, 99) < 5);
      tk = ($urandom_range(0, 99) < 70);
      if ($urandom_range(0, 1) == 1)
        set_ld(0, 0, 0, 0, $urandom_range(0, 1), $urandom_range(0, 63));
      else
        set_ld($urandom_range(0, 63), $urandom_range(0, 15), $urandom_range(0, 31),
               $urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63));
      step("rand", l, sa, sp, tk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
